// File: rtl/config_loader_if.sv
// Host byte stream in, configuration-register write port and status out.
// Latency: none, wiring only.
// Backpressure: the loader drives in_ready; the host holds in_valid/in_data until a transfer occurs.
// Ports:
//   in_valid/in_data/in_ready            host byte handshake
//   cfg_wen/cfg_data                     configuration register write port
//   busy/done/err/err_code               frame status
interface config_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        cfg_wen;
    logic [63:0] cfg_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    // Loader side
    modport slave (
        input  in_valid, in_data,
        output in_ready, cfg_wen, cfg_data, busy, done, err, err_code
    );

    // Host / configuration-register side
    modport master (
        output in_valid, in_data,
        input  in_ready, cfg_wen, cfg_data, busy, done, err, err_code
    );
endinterface

// File: rtl/config_loader.sv
// Assembles header + 8 data bytes (LSB first) + XOR checksum into one 64-bit config write.
// Latency: cfg_wen/done high for the cycle after the checksum byte is accepted.
// Backpressure: in_ready depends on state only; it drops for the single COMMIT cycle.
// Ports:
//   clk   system clock        rst  asynchronous active-low reset
//   bus   config_loader_if.slave (byte handshake in, config write and status out)
module config_loader #(
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    config_loader_if.slave    bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t        state_q,    state_d;
    logic [63:0]   shift_q,    shift_d;
    logic [7:0]    csum_q,     csum_d;
    logic [2:0]    cnt_q,      cnt_d;
    logic [TW-1:0] tmo_q,      tmo_d;
    logic          err_q,      err_d;
    logic [1:0]    err_code_q, err_code_d;

    logic in_ready;
    logic accept;
    logic tmo_hit;

    assign in_ready = (state_q != COMMIT);
    assign accept   = bus.in_valid && in_ready;
    // The counter reaches TIMEOUT_CYCLES on this edge unless a byte is taken;
    // an accept on the same edge takes priority.
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        unique case (state_q)
            IDLE: begin
                if (accept && bus.in_data == HEADER) begin
                    state_d = DATA;
                    cnt_d   = 3'd0;
                    csum_d  = 8'd0;
                    tmo_d   = '0;
                end
            end
            DATA: begin
                if (accept) begin
                    // Header value is ordinary data here; no resync.
                    shift_d = {bus.in_data, shift_q[63:8]};
                    csum_d  = csum_q ^ bus.in_data;
                    cnt_d   = cnt_q + 3'd1;
                    tmo_d   = '0;
                    if (cnt_q == 3'd7) begin
                        state_d = CHECK;
                    end
                end else if (tmo_hit) begin
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    err_code_d = 2'b10;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            CHECK: begin
                if (accept) begin
                    tmo_d = '0;
                    if (bus.in_data == csum_q) begin
                        state_d = COMMIT;
                    end else begin
                        state_d    = IDLE;
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                    end
                end else if (tmo_hit) begin
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    err_code_d = 2'b10;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= 64'd0;
            csum_q     <= 8'd0;
            cnt_q      <= 3'd0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.cfg_wen  = (state_q == COMMIT);
    assign bus.done     = (state_q == COMMIT);
    assign bus.cfg_data = shift_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;

endmodule
